// File: rtl/seg7_reader.sv
// seg7_reader: samples a scanned, active-low 7-segment display bus and
// rebuilds the hex value shown on each of its four digits. A pattern is
// committed only after it has stayed stable for STABLE_CYCLES samples.
module seg7_reader #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic        MAX10_CLK1_50,
  input  logic        rst,
  input  logic [6:0]  SEG,
  input  logic [3:0]  DIG,
  output logic [15:0] CODE,
  output logic [3:0]  VALID,
  output logic [3:0]  ERR,
  output logic        UPD,
  output logic [1:0]  UPD_IDX
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned SMP_W = SEG_W + DIG_W;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } state_e;

  logic [SMP_W-1:0] sync1_q, sync2_q;
  logic [SMP_W-1:0] ref_q, ref_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;

  logic [15:0] code_q;
  logic [3:0]  valid_q, err_q;
  logic        upd_q;
  logic [1:0]  upd_idx_q;

  logic [DIG_W-1:0] dig_s;
  logic [SEG_W-1:0] seg_s, seg_on;
  logic             sel_ok_c, glyph_ok_c, blank_c, commit_c;
  logic [1:0]       sel_idx_c;
  logic [3:0]       glyph_val_c;

  assign dig_s  = sync2_q[SMP_W-1:SEG_W];
  assign seg_s  = sync2_q[SEG_W-1:0];
  assign seg_on = ~seg_s;

  // Two-flop synchronizer; reset parks it at idle/blank (all ones).
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {DIG, SEG};
      sync2_q <= sync1_q;
    end
  end

  // Digit select: legal only with exactly one enable low.
  always_comb begin
    sel_ok_c  = 1'b1;
    sel_idx_c = 2'd0;
    case (dig_s)
      4'b1110: sel_idx_c = 2'd0;
      4'b1101: sel_idx_c = 2'd1;
      4'b1011: sel_idx_c = 2'd2;
      4'b0111: sel_idx_c = 2'd3;
      default: sel_ok_c  = 1'b0;
    endcase
  end

  // Glyph decode on the active-high segment pattern.
  always_comb begin
    glyph_ok_c  = 1'b1;
    glyph_val_c = 4'h0;
    blank_c     = (seg_s == 7'h7F);
    case (seg_on)
      7'h3F: glyph_val_c = 4'h0;
      7'h06: glyph_val_c = 4'h1;
      7'h5B: glyph_val_c = 4'h2;
      7'h4F: glyph_val_c = 4'h3;
      7'h66: glyph_val_c = 4'h4;
      7'h6D: glyph_val_c = 4'h5;
      7'h7D: glyph_val_c = 4'h6;
      7'h07: glyph_val_c = 4'h7;
      7'h7F: glyph_val_c = 4'h8;
      7'h6F: glyph_val_c = 4'h9;
      7'h77: glyph_val_c = 4'hA;
      7'h7C: glyph_val_c = 4'hB;
      7'h39: glyph_val_c = 4'hC;
      7'h5E: glyph_val_c = 4'hD;
      7'h79: glyph_val_c = 4'hE;
      7'h71: glyph_val_c = 4'hF;
      default: glyph_ok_c = 1'b0;
    endcase
  end

  // FSM state, stability counter and reference sample registers.
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      state_q <= ST_WAIT;
      cnt_q   <= '0;
      ref_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
    end
  end

  // Next-state logic: stability tracking and commit decision.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ref_d    = ref_q;
    commit_c = 1'b0;
    if (!sel_ok_c) begin
      state_d = ST_WAIT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_WAIT: begin
          state_d = ST_COUNT;
          cnt_d   = CNT_W'(1);
          ref_d   = sync2_q;
        end
        ST_COUNT: begin
          if (sync2_q == ref_q) begin
            if (cnt_q >= CNT_LAST) begin
              commit_c = 1'b1;
              state_d  = ST_HELD;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            ref_d = sync2_q;
            cnt_d = CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (sync2_q != ref_q) begin
            state_d = ST_COUNT;
            ref_d   = sync2_q;
            cnt_d   = CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Output registers: update only the committed digit's fields.
  always_ff @(posedge MAX10_CLK1_50 or posedge rst) begin
    if (rst) begin
      code_q    <= '0;
      valid_q   <= '0;
      err_q     <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
    end else begin
      upd_q <= commit_c;
      if (commit_c) begin
        upd_idx_q <= sel_idx_c;
        if (glyph_ok_c) begin
          code_q[{sel_idx_c, 2'b00} +: 4] <= glyph_val_c;
          valid_q[sel_idx_c]              <= 1'b1;
          err_q[sel_idx_c]                <= 1'b0;
        end else if (blank_c) begin
          valid_q[sel_idx_c] <= 1'b0;
          err_q[sel_idx_c]   <= 1'b0;
        end else begin
          valid_q[sel_idx_c] <= 1'b0;
          err_q[sel_idx_c]   <= 1'b1;
        end
      end
    end
  end

  assign CODE    = code_q;
  assign VALID   = valid_q;
  assign ERR     = err_q;
  assign UPD     = upd_q;
  assign UPD_IDX = upd_idx_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scenarios plus random display traffic,
// checked by a run-length reference model feeding a scoreboard queue.
module tb_seg7_reader;

  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  dig = 4'hF;
  logic [15:0] code;
  logic [3:0]  valid, err;
  logic        upd;
  logic [1:0]  upd_idx;

  always #5 clk = ~clk;

  seg7_reader #(.STABLE_CYCLES(STABLE)) dut (
    .MAX10_CLK1_50(clk),
    .rst          (rst),
    .SEG          (seg),
    .DIG          (dig),
    .CODE         (code),
    .VALID        (valid),
    .ERR          (err),
    .UPD          (upd),
    .UPD_IDX      (upd_idx)
  );

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] code;
    logic [3:0]  valid;
    logic [3:0]  err;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;

  logic [6:0]  glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model state
  logic [10:0] hist[$];
  logic [10:0] prev;
  int          run;
  logic [15:0] m_code;
  logic [3:0]  m_valid, m_err;
  logic [1:0]  m_idx;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask

  function automatic int sel_index(input logic [3:0] d);
    int zeros = 0;
    int pos = -1;
    for (int i = 0; i < 4; i++)
      if (!d[i]) begin
        zeros++;
        pos = i;
      end
    return (zeros == 1) ? pos : -1;
  endfunction

  function automatic int glyph_value(input logic [6:0] s);
    logic [6:0] on;
    on = ~s;
    for (int g = 0; g < 16; g++)
      if (glyph[g] == on) return g;
    return -1;
  endfunction

  // Model: a value seen on the pins reaches the decision logic two edges
  // later; a legal value commits when seen on STABLE consecutive edges.
  always @(posedge clk) begin
    if (rst) begin
      hist    = '{11'h7FF, 11'h7FF};
      prev    = 11'h7FF;
      run     = 0;
      m_code  = '0;
      m_valid = '0;
      m_err   = '0;
      m_idx   = '0;
    end else begin
      logic [10:0] s;
      int idx, g, old_run;
      s = hist.pop_front();
      hist.push_back({dig, seg});
      idx = sel_index(s[10:7]);
      old_run = run;
      if (idx < 0) run = 0;
      else if (run > 0 && s == prev) run = (run < STABLE) ? run + 1 : run;
      else run = 1;
      prev = s;
      if (idx >= 0 && run == STABLE && old_run != STABLE) begin
        exp_t e;
        g = glyph_value(s[6:0]);
        m_idx = 2'(idx);
        if (g >= 0) begin
          m_code[idx*4 +: 4] = 4'(g);
          m_valid[idx] = 1'b1;
          m_err[idx]   = 1'b0;
        end else if (s[6:0] == 7'h7F) begin
          m_valid[idx] = 1'b0;
          m_err[idx]   = 1'b0;
        end else begin
          m_valid[idx] = 1'b0;
          m_err[idx]   = 1'b1;
        end
        e.idx = m_idx; e.code = m_code; e.valid = m_valid; e.err = m_err;
        sbq.push_back(e);
      end
    end
  end

  // Monitor: pop the scoreboard on each UPD and check held outputs every cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("reset_outputs", 32'({code, valid, err, upd, upd_idx}), 32'd0);
    end else begin
      if (upd) begin
        if (sbq.size() == 0) begin
          check("spurious_upd", 32'(upd), 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("upd_payload", 32'({upd_idx, code, valid, err}), 32'(e));
        end
      end else if (sbq.size() != 0) begin
        void'(sbq.pop_front());
        check("missing_upd", 32'(upd), 32'd1);
      end
      check("held_state", 32'({upd_idx, code, valid, err}),
            32'({m_idx, m_code, m_valid, m_err}));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] d, input logic [6:0] s, input int n);
    dig = d;
    seg = s;
    tick(n);
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    // glyph 0 on digit 0
    hold(4'b1110, 7'h40, 10);
    // F on digit 2, held long: single commit
    hold(4'b1011, 7'h0E, 20);
    // toggling faster than the stability window: no commits
    for (int i = 0; i < 6; i++) begin
      hold(4'b1101, 7'h79, 3);
      hold(4'b1101, 7'h24, 3);
    end
    // illegal selections
    hold(4'b0011, 7'h40, 10);
    hold(4'b1111, 7'h40, 10);
    // 8 then an illegal pattern on digit 3
    hold(4'b0111, 7'h00, 10);
    hold(4'b0111, 7'h7E, 10);
    // blank on digit 0
    hold(4'b1110, 7'h7F, 10);
    // reset in the middle of a pending commit, then recommit
    hold(4'b1101, 7'h19, 4);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    hold(4'b1101, 7'h19, 10);
    // random traffic
    for (int k = 0; k < 150; k++) begin
      logic [3:0] d;
      logic [6:0] s;
      int r, q;
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        d = 4'hF;
        d[$urandom_range(0, 3)] = 1'b0;
      end else if (r == 7) d = 4'hF;
      else d = 4'($urandom);
      q = int'($urandom_range(0, 9));
      if (q < 7) s = ~glyph[$urandom_range(0, 15)];
      else if (q == 7) s = 7'h7F;
      else s = 7'($urandom);
      hold(d, s, int'($urandom_range(1, 9)));
      if (k == 75) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
    end
    hold(4'hF, 7'h7F, 6);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 The module SHALL have parameter STABLE_CYCLES, default 4, range 2-255: the number of consecutive identical synchronized samples required before a digit is committed.
REQ-002 MAX10_CLK1_50  input  1  the single clock; all logic SHALL be on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 SEG  input  7  active-low segment bus; bit0=a … bit6=g, with the same polarity and ordering as the HEX0 outputs.
REQ-005 DIG  input  4  active-low digit enables of a scanned display; exactly one bit low means digit index = position of that low bit.
REQ-006 CODE  output  16  decoded values; nibble i (CODE[4i+3:4i]) belongs to digit i.
REQ-007 VALID  output  4  bit i is set when digit i holds a legal hex glyph.
REQ-008 ERR  output  4  bit i is set when digit i holds an illegal pattern.
REQ-009 UPD  output  1  one-cycle pulse on every commit.
REQ-010 UPD_IDX  output  2  digit index of the most recent commit; held between commits.

Function
REQ-011 SEG and DIG SHALL each pass through a two-flop synchronizer; all further logic SHALL use only the synchronized sample S = {DIG_s, SEG_s}.
REQ-012 The FSM SHALL have three states: WAIT, COUNT and HELD, and a stability counter cnt (8 bits).
REQ-013 Selection is legal only when DIG_s has exactly one bit low; values 4'b1111 and any value with more than one low bit are illegal.
REQ-014 In any state, an illegal selection SHALL force the next state to WAIT with cnt=0 and SHALL NOT cause a commit.
REQ-015 WAIT to COUNT: taken on a legal selection, with cnt=1 and S latched as reference R.
REQ-016 COUNT, S equal to R: cnt SHALL increment.
REQ-017 COUNT, S equal to R and cnt=STABLE_CYCLES-1: the block SHALL commit on that edge and go to HELD.
REQ-018 COUNT, S not equal to R: the block SHALL reload R=S, set cnt=1 and stay in COUNT.
REQ-019 HELD, S equal to R: the block SHALL stay in HELD and SHALL NOT re-commit.
REQ-020 HELD, S not equal to R (legal): the block SHALL go to COUNT with R=S and cnt=1.
REQ-021 A pattern held constant on the pins SHALL commit on rising edge STABLE_CYCLES+2, counting the first edge that samples it as edge 1.
REQ-022 UPD SHALL be high during the cycle immediately after the commit edge, and only that cycle.
REQ-023 UPD_IDX SHALL update on the commit edge.
REQ-024 Decode SHALL use the inverted active-high g..a values 0x3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71 for hex digits 0-F.
REQ-025 Commit of a legal glyph: CODE nibble i SHALL take the decoded value, VALID[i]=1, ERR[i]=0.
REQ-026 Commit of blank (SEG_s=7'h7F): VALID[i]=0 and ERR[i]=0, and the CODE nibble SHALL be unchanged.
REQ-027 Commit of any other pattern: VALID[i]=0 and ERR[i]=1, and the CODE nibble SHALL be unchanged.
REQ-028 A commit SHALL modify only the fields of digit i; the other digits SHALL hold their values.
REQ-029 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL NOT wrap.

Reset
REQ-030 When rst is high, the following SHALL clear asynchronously: synchronizers to all-ones (idle, blank), FSM=WAIT, cnt=0, R=all-ones.
REQ-031 When rst is high, the outputs SHALL be CODE=16'h0000, VALID=4'h0, ERR=4'h0, UPD=0, UPD_IDX=2'd0.
REQ-032 rst asserted mid-COUNT SHALL abort the pending commit, with no UPD pulse.
REQ-033 After reset deassertion, counting SHALL restart from WAIT.

Verification
REQ-034 STABLE_CYCLES=4, DIG=4'b1110, SEG=7'h40 (glyph 0) held: response is UPD on the cycle after edge 6, UPD_IDX=0, CODE[3:0]=0, VALID=4'b0001.
REQ-035 DIG=4'b1011, SEG=7'h0E (F) held for 20 cycles: response is exactly one UPD pulse, CODE[11:8]=F, VALID[2]=1, and other nibbles unchanged.
REQ-036 Pattern toggling every 3 cycles with STABLE_CYCLES=4: response is no UPD, and all outputs held.
REQ-037 DIG=4'b0011 or 4'b1111 with a valid SEG held for 10 cycles: response is no UPD, and the FSM stays in WAIT.
REQ-038 DIG=4'b0111, SEG=7'h00 (all on, which is digit 8 and therefore legal) then SEG=7'h7E (illegal): the first commit gives CODE[15:12]=8 and VALID[3]=1; the second gives ERR[3]=1, VALID[3]=0, and CODE[15:12] still 8.
REQ-039 Assert rst at cnt=2 of a pending commit: response is no UPD, all outputs at reset values, and after release the commit occurs STABLE_CYCLES+2 edges later.
